word_serializer: RTL and testbench

//   Parallel-to-serial front end for the serial sequence-detector FSMs. It accepts

---
 rtl/word_serializer.sv | 89 ++++++++
 tb/tb_word_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words over valid/ready and emits one bit
// per enabled clock. A one-word holding buffer lets consecutive words stream without a gap.
module word_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_in_data,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_enable,
  output logic             o_a,
  output logic             o_a_valid,
  output logic             o_last,
  output logic             o_busy
);

  localparam int unsigned       CntW    = $clog2(WIDTH);
  localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

  typedef enum logic {StIdle, StShift} state_e;

  state_e            r_state;
  logic [WIDTH-1:0]  r_sr;
  logic [WIDTH-1:0]  r_hb;
  logic              r_hb_full;
  logic [CntW-1:0]   r_cnt;

  logic              w_accept;
  logic              w_word_end;
  logic              w_out_bit;
  logic [WIDTH-1:0]  w_sr_shifted;

  assign o_in_ready   = ~i_reset & ~r_hb_full;
  assign w_accept     = i_in_valid & o_in_ready;
  assign o_a_valid    = (r_state == StShift);
  assign w_out_bit    = MSB_FIRST ? r_sr[WIDTH-1] : r_sr[0];
  assign o_a          = o_a_valid ? w_out_bit : IDLE_BIT;
  assign o_last       = o_a_valid & (r_cnt == CntLast);
  assign o_busy       = o_a_valid | r_hb_full;
  assign w_word_end   = o_last & i_enable;
  // Shift toward whichever end drives the output.
  assign w_sr_shifted = MSB_FIRST ? {r_sr[WIDTH-2:0], 1'b0} : {1'b0, r_sr[WIDTH-1:1]};

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_hb_full <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_sr    <= i_in_data;
            r_cnt   <= '0;
            r_state <= StShift;
          end
        end
        StShift: begin
          if (w_word_end) begin
            r_cnt <= '0;
            // Buffered word wins; in_ready is low while it is held, so no accept can clash.
            if (r_hb_full) begin
              r_sr      <= r_hb;
              r_hb_full <= 1'b0;
            end else if (w_accept) begin
              r_sr <= i_in_data;
            end else begin
              r_state <= StIdle;
            end
          end else begin
            if (i_enable) begin
              r_sr  <= w_sr_shifted;
              r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
              r_hb      <= i_in_data;
              r_hb_full <= 1'b1;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: directed scenarios plus a randomized run, both checked against
// a queue-of-words model; an MSB-first and an LSB-first instance share the same stimulus.
module tb_word_serializer;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         enable;

  logic m_ready, m_a, m_valid, m_last, m_busy;
  logic l_ready, l_a, l_valid, l_last, l_busy;

  int checks = 0;
  int errors = 0;

  // Model: words waiting or being shifted (front = on the wire), and bit index in the front word.
  logic [W-1:0] mq[$];
  int           mpos = 0;

  // Values sampled in the most recent cycle.
  logic s_a_m, s_a_l, s_valid, s_last, s_busy, s_ready;

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_dut_msb (
    .i_clock   (clk),
    .i_reset   (reset),
    .i_in_data (in_data),
    .i_in_valid(in_valid),
    .o_in_ready(m_ready),
    .i_enable  (enable),
    .o_a       (m_a),
    .o_a_valid (m_valid),
    .o_last    (m_last),
    .o_busy    (m_busy)
  );

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_lsb (
    .i_clock   (clk),
    .i_reset   (reset),
    .i_in_data (in_data),
    .i_in_valid(in_valid),
    .o_in_ready(l_ready),
    .i_enable  (enable),
    .o_a       (l_a),
    .o_a_valid (l_valid),
    .o_last    (l_last),
    .o_busy    (l_busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample and check at negedge, then advance the model across the posedge.
  task automatic cycle();
    logic         e_valid;
    logic [W-1:0] word;
    logic         acc;
    @(negedge clk);
    e_valid = (mq.size() > 0);
    word    = e_valid ? mq[0] : '0;
    s_a_m   = m_a;
    s_a_l   = l_a;
    s_valid = m_valid;
    s_last  = m_last;
    s_busy  = m_busy;
    s_ready = m_ready;
    check_eq("msb_a_valid", 32'(m_valid), 32'(e_valid));
    check_eq("msb_a", 32'(m_a), e_valid ? 32'(word[W-1-mpos]) : 32'd1);
    check_eq("msb_last", 32'(m_last), 32'(e_valid && mpos == W - 1));
    check_eq("msb_busy", 32'(m_busy), 32'(e_valid));
    check_eq("msb_ready", 32'(m_ready), 32'(!reset && mq.size() < 2));
    check_eq("lsb_a_valid", 32'(l_valid), 32'(e_valid));
    check_eq("lsb_a", 32'(l_a), e_valid ? 32'(word[mpos]) : 32'd0);
    check_eq("lsb_last", 32'(l_last), 32'(e_valid && mpos == W - 1));
    check_eq("lsb_busy", 32'(l_busy), 32'(e_valid));
    check_eq("lsb_ready", 32'(l_ready), 32'(!reset && mq.size() < 2));
    @(posedge clk);
    acc = in_valid && !reset && mq.size() < 2;
    if (reset) begin
      mq.delete();
      mpos = 0;
    end else begin
      if (mq.size() > 0 && enable) begin
        if (mpos == W - 1) begin
          void'(mq.pop_front());
          mpos = 0;
        end else begin
          mpos++;
        end
      end
      if (acc) mq.push_back(in_data);
    end
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    enable   = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] vm, vl, lmask;
    logic [7:0]  fmask;
    logic [2:0]  hist;
    int          nvalid, npos;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    enable   = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
    mpos = 0;
    do_reset();
    check_eq("reset_a", 32'(s_a_m), 32'd1);
    check_eq("reset_busy", 32'(s_busy), 32'd0);

    // Single word A5, MSB first.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    cycle();
    in_valid = 1'b0;
    vm = '0; lmask = '0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      vm    = {vm[14:0], s_a_m};
      lmask = {lmask[14:0], s_last};
    end
    check_eq("a5_bits", 32'(vm[7:0]), 32'hA5);
    check_eq("a5_last_mask", 32'(lmask[7:0]), 32'h01);
    cycle();
    check_eq("a5_after_valid", 32'(s_valid), 32'd0);
    check_eq("a5_after_a", 32'(s_a_m), 32'd1);
    check_eq("a5_after_busy", 32'(s_busy), 32'd0);

    // Back-to-back 01 then FF; LSB-first instance covers bit order reversal.
    in_valid = 1'b1;
    in_data  = 8'h01;
    cycle();
    in_data = 8'hFF;
    cycle();
    in_valid = 1'b0;
    check_eq("b2b_ready_hb_full", 32'(m_ready), 32'd0);
    vm = '0; vl = '0; nvalid = 0;
    // Cycle of FF acceptance already showed bit 0 of word 01.
    vm = {15'd0, s_a_m};
    vl = {15'd0, s_a_l};
    nvalid = int'(s_valid);
    for (int i = 0; i < 15; i++) begin
      cycle();
      vm = {vm[14:0], s_a_m};
      vl = {vl[14:0], s_a_l};
      nvalid += int'(s_valid);
    end
    check_eq("b2b_msb_bits", 32'(vm), 32'h01FF);
    check_eq("b2b_lsb_bits", 32'(vl), 32'h80FF);
    check_eq("b2b_no_gap", 32'(nvalid), 32'd16);
    cycle();
    check_eq("b2b_done", 32'(s_valid), 32'd0);

    // C3 with enable alternating: each bit held two cycles.
    in_valid = 1'b1;
    in_data  = 8'hC3;
    enable   = 1'b1;
    cycle();
    in_valid = 1'b0;
    vm = '0; lmask = '0;
    for (int i = 0; i < 16; i++) begin
      enable = (i % 2 == 1);
      cycle();
      vm    = {vm[14:0], s_a_m};
      lmask = {lmask[14:0], s_last};
    end
    enable = 1'b1;
    check_eq("stall_bits", 32'(vm), 32'hF00F);
    check_eq("stall_last_mask", 32'(lmask), 32'h0003);
    cycle();
    check_eq("stall_done", 32'(s_valid), 32'd0);

    // Reset mid-word with a word buffered.
    in_valid = 1'b1;
    in_data  = 8'hF0;
    cycle();
    in_data = 8'h0F;
    cycle();
    in_valid = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check_eq("rst_mid_valid", 32'(s_valid), 32'd0);
    check_eq("rst_mid_busy", 32'(s_busy), 32'd0);
    check_eq("rst_mid_ready", 32'(s_ready), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      nvalid += int'(s_valid);
    end
    check_eq("rst_mid_no_bits", 32'(nvalid), 32'd0);

    // 010 detection on stream 52 (01010010): hits end at positions 3, 5, 8.
    in_valid = 1'b1;
    in_data  = 8'h52;
    cycle();
    in_valid = 1'b0;
    fmask = '0; hist = '0; npos = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (s_valid) begin
        hist = {hist[1:0], s_a_m};
        npos++;
        if (npos >= 3 && hist == 3'b010 && npos <= 8) fmask[npos-1] = 1'b1;
      end
    end
    check_eq("det010_positions", 32'(fmask), 32'h94);
    check_eq("det010_bitcount", 32'(npos), 32'd8);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 1) == 1);
      in_data  = W'($urandom);
      enable   = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
